bus_arbiter_rr: RTL and testbench

- Round-robin arbiter/sequencer for the shared memory-subsystem system bus (bus_addr/bus_data/bus_rd_wr/bus_en).
- Requesters: icache, dcache, DMA, system controller.
- Issues a one-hot registered grant and tracks bus ownership until release.
- Inserts one turnaround cycle between owners for the tri-state bus_data.
- Runs a watchdog that revokes the grant from a hung owner.

---
 rtl/bus_arb_pkg.sv | 22 ++
 rtl/bus_arbiter_rr_pick.sv | 36 +++
 rtl/bus_arbiter_rr.sv | 103 ++++++++++
 tb/tb_bus_arbiter_rr.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// rtl/bus_arb_pkg.sv - shared constants and helpers for the system bus round-robin arbiter
package bus_arb_pkg;

  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_OWN  = 2'd1;
  localparam logic [1:0] ARB_TURN = 2'd2;

  localparam int REQ_ICACHE = 0;
  localparam int REQ_DCACHE = 1;
  localparam int REQ_DMA    = 2;
  localparam int REQ_SYSC   = 3;

  localparam int ARB_NREQ    = 4;
  localparam int ARB_IDW     = 2;
  localparam int ARB_TIMEOUT = 255;
  localparam int ARB_TOW     = 8;

  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// rtl/bus_arbiter_rr_pick.sv - combinational round-robin pick: rotate by ptr, priority-encode, rotate back
module rr_pick
  import bus_arb_pkg::*;
#(
  parameter int NREQ = ARB_NREQ,
  parameter int IDW  = ARB_IDW
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            any,
  output logic [IDW-1:0]  winner,
  output logic [NREQ-1:0] onehot
);

  logic [NREQ-1:0] rot;
  logic [IDW-1:0]  idx;

  always_comb begin
    rot = '0;
    for (int i = 0; i < NREQ; i++) begin
      rot[i] = req[(i + int'(ptr)) % NREQ];
    end

    // Lowest set bit of the rotated vector is the first requester at or after ptr.
    idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) idx = IDW'(i);
    end

    any    = |rot;
    winner = IDW'((int'(idx) + int'(ptr)) % NREQ);
    onehot = '0;
    if (any) onehot[winner] = 1'b1;
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// rtl/bus_arbiter_rr.sv - round-robin system bus arbiter with turnaround cycle and ownership watchdog
module bus_arbiter_rr
  import bus_arb_pkg::*;
#(
  parameter int NREQ    = ARB_NREQ,
  parameter int IDW     = ARB_IDW,
  parameter int TIMEOUT = ARB_TIMEOUT,
  parameter int TOW     = ARB_TOW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] done,
  output logic [NREQ-1:0] grant,
  output logic            grant_valid,
  output logic [IDW-1:0]  owner_id,
  output logic            bus_busy,
  output logic            timeout_err,
  output logic [IDW-1:0]  timeout_id
);

  logic [1:0]      state;
  logic [IDW-1:0]  ptr;
  logic [TOW-1:0]  count;

  logic            pick_any;
  logic [IDW-1:0]  pick_winner;
  logic [NREQ-1:0] pick_onehot;

  logic            owner_release;
  logic            timeout_hit;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .any    (pick_any),
    .winner (pick_winner),
    .onehot (pick_onehot)
  );

  // Only the current owner's lines matter; non-owner done/req are ignored.
  assign owner_release = done[owner_id] | ~req[owner_id];
  assign timeout_hit   = (count == TOW'(TIMEOUT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ARB_IDLE;
      ptr         <= '0;
      count       <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      owner_id    <= '0;
      bus_busy    <= 1'b0;
      timeout_err <= 1'b0;
      timeout_id  <= '0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (pick_any) begin
            grant       <= pick_onehot;
            grant_valid <= 1'b1;
            owner_id    <= pick_winner;
            ptr         <= IDW'(wrap_inc(32'(pick_winner), NREQ));
            count       <= '0;
            bus_busy    <= 1'b1;
            state       <= ARB_OWN;
          end
        end
        ARB_OWN: begin
          // A release wins over a coincident watchdog expiry.
          if (owner_release) begin
            grant       <= '0;
            grant_valid <= 1'b0;
            state       <= ARB_TURN;
          end else if (timeout_hit) begin
            grant       <= '0;
            grant_valid <= 1'b0;
            timeout_err <= 1'b1;
            timeout_id  <= owner_id;
            state       <= ARB_TURN;
          end else begin
            count <= count + 1'b1;
          end
        end
        ARB_TURN: begin
          bus_busy <= 1'b0;
          state    <= ARB_IDLE;
        end
        default: begin
          grant       <= '0;
          grant_valid <= 1'b0;
          bus_busy    <= 1'b0;
          state       <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb/tb_bus_arbiter_rr.sv - randomized bench for bus_arbiter_rr against a transaction-level model
module tb_bus_arbiter_rr;

  localparam int NREQ    = 4;
  localparam int IDW     = 2;
  localparam int TIMEOUT = 255;
  localparam int TOW     = 8;

  logic            clk;
  logic            rst_n;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] done;
  logic [NREQ-1:0] grant;
  logic            grant_valid;
  logic [IDW-1:0]  owner_id;
  logic            bus_busy;
  logic            timeout_err;
  logic [IDW-1:0]  timeout_id;

  int n_checks;
  int n_pass;

  // Model: who owns the bus, for how long, whether a turnaround is pending, and where the scan starts.
  int m_owner;
  int m_age;
  bit m_turn;
  int m_next;
  int m_last_owner;
  bit m_terr;
  int m_tid;

  bus_arbiter_rr #(
    .NREQ    (NREQ),
    .IDW     (IDW),
    .TIMEOUT (TIMEOUT),
    .TOW     (TOW)
  ) dut (
    .clk         (clk),
    .reset       (rst_n),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_valid (grant_valid),
    .owner_id    (owner_id),
    .bus_busy    (bus_busy),
    .timeout_err (timeout_err),
    .timeout_id  (timeout_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
  endtask

  task automatic model_reset();
    m_owner      = -1;
    m_age        = 0;
    m_turn       = 1'b0;
    m_next       = 0;
    m_last_owner = 0;
    m_terr       = 1'b0;
    m_tid        = 0;
  endtask

  task automatic model_step(input logic [NREQ-1:0] r, input logic [NREQ-1:0] d);
    m_terr = 1'b0;
    if (m_owner >= 0) begin
      if (d[m_owner] || !r[m_owner]) begin
        m_owner = -1;
        m_turn  = 1'b1;
      end else if (m_age == TIMEOUT) begin
        m_terr  = 1'b1;
        m_tid   = m_owner;
        m_owner = -1;
        m_turn  = 1'b1;
      end else begin
        m_age++;
      end
    end else if (m_turn) begin
      m_turn = 1'b0;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (m_next + k) % NREQ;
        if (r[idx] && m_owner < 0) begin
          m_owner      = idx;
          m_last_owner = idx;
          m_age        = 0;
          m_next       = (idx + 1) % NREQ;
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [NREQ-1:0] exp_grant;
    exp_grant = '0;
    if (m_owner >= 0) exp_grant[m_owner] = 1'b1;
    chk("grant",       32'(grant),       32'(exp_grant));
    chk("grant_valid", 32'(grant_valid), 32'(m_owner >= 0));
    chk("owner_id",    32'(owner_id),    32'(m_last_owner));
    chk("bus_busy",    32'(bus_busy),    32'((m_owner >= 0) || m_turn));
    chk("timeout_err", 32'(timeout_err), 32'(m_terr));
    chk("timeout_id",  32'(timeout_id),  32'(m_tid));
    chk("onehot0",     32'($onehot0(grant)), 32'd1);
  endtask

  task automatic cycle(input logic [NREQ-1:0] r, input logic [NREQ-1:0] d);
    req  = r;
    done = d;
    @(posedge clk);
    model_step(r, d);
    @(negedge clk);
    check_outputs();
  endtask

  // Reset is applied between edges so the check proves the outputs clear without a clock.
  task automatic reset_dut();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_grant", 32'(grant),       32'd0);
    chk("rst_busy",  32'(bus_busy),    32'd0);
    chk("rst_gv",    32'(grant_valid), 32'd0);
    chk("rst_terr",  32'(timeout_err), 32'd0);
    model_reset();
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
  endtask

  function automatic logic [NREQ-1:0] owner_done();
    logic [NREQ-1:0] v;
    v = '0;
    if (m_owner >= 0) v[m_owner] = 1'b1;
    return v;
  endfunction

  initial begin
    logic [NREQ-1:0] rq;
    logic [NREQ-1:0] dn;
    logic [NREQ-1:0] prev;
    logic [NREQ-1:0] order_q[$];
    logic [NREQ-1:0] exp_order[5];
    int grant2_cycles;
    int terr_pulses;
    logic [NREQ-1:0] after_to;

    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    req      = '0;
    done     = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    // Single requester grant, release by done, turnaround, idle.
    cycle(4'b0010, 4'b0000);
    chk("t1_grant", 32'(grant), 32'h2);
    chk("t1_owner", 32'(owner_id), 32'd1);
    cycle(4'b0010, 4'b0010);
    chk("t1_turn_busy", 32'(bus_busy), 32'd1);
    chk("t1_turn_grant", 32'(grant), 32'd0);
    cycle(4'b0000, 4'b0000);
    chk("t1_idle_busy", 32'(bus_busy), 32'd0);

    // All requesting, each owner releases after 3 OWN cycles.
    reset_dut();
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    prev = '0;
    for (int i = 0; i < 30; i++) begin
      dn = (m_owner >= 0 && m_age == 2) ? owner_done() : '0;
      cycle(4'b1111, dn);
      if (grant != 0 && grant != prev) order_q.push_back(grant);
      prev = grant;
    end
    chk("t2_order_len", 32'(order_q.size() >= 5), 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i < order_q.size()) chk("t2_order", 32'(order_q[i]), 32'(exp_order[i]));
    end

    // Hung owner 2 is revoked by the watchdog; owner 3 follows.
    reset_dut();
    cycle(4'b0100, 4'b0000);
    grant2_cycles = 1;
    terr_pulses   = 0;
    after_to      = '0;
    for (int i = 0; i < 300; i++) begin
      cycle(4'b1100, 4'b0000);
      if (grant == 4'b0100) grant2_cycles++;
      if (timeout_err) terr_pulses++;
      if (after_to == 0 && grant != 0 && grant != 4'b0100) after_to = grant;
    end
    chk("t3_own_cycles", 32'(grant2_cycles), 32'(TIMEOUT + 1));
    chk("t3_terr_pulses", 32'(terr_pulses), 32'd1);
    chk("t3_tid", 32'(timeout_id), 32'd2);
    chk("t3_next", 32'(after_to), 32'h8);

    // done arriving in the same cycle as watchdog expiry is a normal release.
    reset_dut();
    terr_pulses = 0;
    for (int i = 0; i < 270; i++) begin
      dn = (m_owner == 2 && m_age == TIMEOUT) ? 4'b0100 : 4'b0000;
      cycle(4'b0100, dn);
      if (timeout_err) terr_pulses++;
    end
    chk("t4_no_terr", 32'(terr_pulses), 32'd0);

    // Non-owner done pulses are ignored.
    reset_dut();
    cycle(4'b0010, 4'b0000);
    cycle(4'b1011, 4'b1001);
    chk("t5_grant_held", 32'(grant), 32'h2);
    cycle(4'b1011, 4'b0000);
    chk("t5_grant_held2", 32'(grant), 32'h2);

    // Reset mid-ownership, then re-arbitration from ptr=0.
    reset_dut();
    cycle(4'b0100, 4'b0000);
    cycle(4'b0100, 4'b0000);
    chk("t6_owned", 32'(grant), 32'h4);
    reset_dut();
    cycle(4'b0100, 4'b0000);
    chk("t6_regrant", 32'(grant), 32'h4);

    // Random traffic: requests toggle, owners release or drop, stray done pulses.
    rq = '0;
    for (int i = 0; i < 2500; i++) begin
      for (int b = 0; b < NREQ; b++) begin
        if ($urandom_range(0, 15) == 0) rq[b] = ~rq[b];
      end
      dn = '0;
      for (int b = 0; b < NREQ; b++) begin
        if ($urandom_range(0, 7) == 0) dn[b] = 1'b1;
      end
      if (m_owner >= 0) begin
        rq[m_owner] = ($urandom_range(0, 49) != 0);
        dn[m_owner] = ($urandom_range(0, 5) == 0);
      end
      cycle(rq, dn);
    end

    // Everyone hangs: every owner times out in turn and rejoins the rotation.
    for (int i = 0; i < 1400; i++) begin
      dn = '0;
      for (int b = 0; b < NREQ; b++) begin
        if ($urandom_range(0, 7) == 0 && b != m_owner) dn[b] = 1'b1;
      end
      cycle(4'b1111, dn);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
